// File: rtl/csel_pkg.sv
// Shared constants and types for the carry-select subtractor family.
// The block partition (LSB first) is 2,2,3,4,5,6,7,3 bits. The adder uses the
// same partition, so the two blocks have matching timing.
package csel_pkg;

  localparam int NBLK          = 8;
  localparam int SPLIT_BLK_DEF = 4;

  // Width and LSB offset of each carry-select block.
  localparam int BLK_W   [NBLK] = '{2, 2, 3, 4, 5, 6, 7, 3};
  localparam int BLK_LSB [NBLK] = '{0, 2, 4, 7, 11, 16, 22, 29};

  typedef struct packed {
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
  } result_t;

endpackage

// File: rtl/csel_block.sv
// One carry-select block: two independent ripple chains over the same operand
// slice. One chain assumes carry-in 0 and the other assumes carry-in 1. The
// caller picks one result once the real carry is known.
module csel_block #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] bn,
  output logic [W-1:0] sum0,
  output logic         c0,
  output logic [W-1:0] sum1,
  output logic         c1
);

  // Dual ripple: r0 starts at 0 and r1 starts at 1.
  always_comb begin
    logic r0;
    logic r1;
    sum0 = '0;
    sum1 = '0;
    r0   = 1'b0;
    r1   = 1'b1;
    for (int i = 0; i < W; i++) begin
      sum0[i] = a[i] ^ bn[i] ^ r0;
      sum1[i] = a[i] ^ bn[i] ^ r1;
      r0      = (a[i] & bn[i]) | (r0 & (a[i] ^ bn[i]));
      r1      = (a[i] & bn[i]) | (r1 & (a[i] ^ bn[i]));
    end
    c0 = r0;
    c1 = r1;
  end

endmodule

// File: rtl/csel_subtractor_pipe.sv
// Two-stage carry-select subtractor, diff = a + ~b + 1, with valid/ready on both sides.
// Stage 1 resolves blocks below SPLIT_BLK. It also registers both candidate
// results for the upper blocks. Stage 2 runs the upper select chain from the
// registered split carry and registers the final result and flags.
module csel_subtractor_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SPLIT_BLK = SPLIT_BLK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int LOW_W = BLK_LSB[SPLIT_BLK];
  localparam int HI_W  = WIDTH - LOW_W;
  localparam int NHI   = NBLK - SPLIT_BLK;

  logic [WIDTH-1:0] b_n;
  logic [WIDTH-1:0] cand_sum0, cand_sum1;
  logic [NBLK-1:0]  cand_c0, cand_c1;

  assign b_n = ~b;

  // Both candidate results for every block, computed from the raw operands.
  for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
    csel_block #(.W(BLK_W[gi])) u_blk (
      .a    (a[BLK_LSB[gi] +: BLK_W[gi]]),
      .bn   (b_n[BLK_LSB[gi] +: BLK_W[gi]]),
      .sum0 (cand_sum0[BLK_LSB[gi] +: BLK_W[gi]]),
      .c0   (cand_c0[gi]),
      .sum1 (cand_sum1[BLK_LSB[gi] +: BLK_W[gi]]),
      .c1   (cand_c1[gi])
    );
  end

  // Handshake: each stage advances when its downstream is empty or draining.
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv, accept, s2_load;

  assign s2_adv    = !s2_valid_q | out_ready;
  assign s1_adv    = !s1_valid_q | s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid & in_ready;
  assign s2_load   = s2_adv & s1_valid_q;
  assign out_valid = s2_valid_q;

  // Stage 1 lower select chain: block 0 gets carry-in 1, which forms the +1 of the two's complement.
  logic [LOW_W-1:0] low_sum;
  logic             c_split;

  always_comb begin
    logic c;
    low_sum = '0;
    c       = 1'b1;
    for (int k = 0; k < SPLIT_BLK; k++) begin
      for (int j = 0; j < BLK_W[k]; j++) begin
        low_sum[BLK_LSB[k] + j] = c ? cand_sum1[BLK_LSB[k] + j] : cand_sum0[BLK_LSB[k] + j];
      end
      c = c ? cand_c1[k] : cand_c0[k];
    end
    c_split = c;
  end

  logic [LOW_W-1:0] s1_low_q, s1_low_d;
  logic             s1_csplit_q, s1_csplit_d;
  logic [HI_W-1:0]  s1_sum0_q, s1_sum0_d, s1_sum1_q, s1_sum1_d;
  logic [NHI-1:0]   s1_c0_q, s1_c0_d, s1_c1_q, s1_c1_d;
  logic             s1_a31_q, s1_a31_d, s1_nb31_q, s1_nb31_d;

  // Stage 1 next state: the occupancy follows s1_adv, and the data loads only on accept.
  always_comb begin
    s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
    s1_low_d    = s1_low_q;
    s1_csplit_d = s1_csplit_q;
    s1_sum0_d   = s1_sum0_q;
    s1_sum1_d   = s1_sum1_q;
    s1_c0_d     = s1_c0_q;
    s1_c1_d     = s1_c1_q;
    s1_a31_d    = s1_a31_q;
    s1_nb31_d   = s1_nb31_q;
    if (accept) begin
      s1_low_d    = low_sum;
      s1_csplit_d = c_split;
      s1_sum0_d   = cand_sum0[WIDTH-1:LOW_W];
      s1_sum1_d   = cand_sum1[WIDTH-1:LOW_W];
      s1_c0_d     = cand_c0[NBLK-1:SPLIT_BLK];
      s1_c1_d     = cand_c1[NBLK-1:SPLIT_BLK];
      s1_a31_d    = a[WIDTH-1];
      s1_nb31_d   = b_n[WIDTH-1];
    end
  end

  // Stage 2 upper select chain and flags, driven by the registered split carry.
  result_t res_q, res_d;

  always_comb begin
    logic             c;
    logic [HI_W-1:0]  hi_sum;
    logic [WIDTH-1:0] full;
    hi_sum = '0;
    c      = s1_csplit_q;
    for (int k = SPLIT_BLK; k < NBLK; k++) begin
      for (int j = 0; j < BLK_W[k]; j++) begin
        hi_sum[BLK_LSB[k] - LOW_W + j] = c ? s1_sum1_q[BLK_LSB[k] - LOW_W + j]
                                           : s1_sum0_q[BLK_LSB[k] - LOW_W + j];
      end
      c = c ? s1_c1_q[k - SPLIT_BLK] : s1_c0_q[k - SPLIT_BLK];
    end
    full       = {hi_sum, s1_low_q};
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    res_d      = res_q;
    if (s2_load) begin
      res_d.diff = full;
      res_d.bout = ~c;
      res_d.zero = (full == '0);
      res_d.ovf  = (s1_a31_q ^ ~s1_nb31_q) & (full[WIDTH-1] ^ s1_a31_q);
    end
  end

  assign diff = res_q.diff;
  assign bout = res_q.bout;
  assign zero = res_q.zero;
  assign ovf  = res_q.ovf;

  // Pipeline registers: an asynchronous reset empties both stages and clears the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_low_q    <= '0;
      s1_csplit_q <= 1'b0;
      s1_sum0_q   <= '0;
      s1_sum1_q   <= '0;
      s1_c0_q     <= '0;
      s1_c1_q     <= '0;
      s1_a31_q    <= 1'b0;
      s1_nb31_q   <= 1'b0;
      res_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s1_low_q    <= s1_low_d;
      s1_csplit_q <= s1_csplit_d;
      s1_sum0_q   <= s1_sum0_d;
      s1_sum1_q   <= s1_sum1_d;
      s1_c0_q     <= s1_c0_d;
      s1_c1_q     <= s1_c1_d;
      s1_a31_q    <= s1_a31_d;
      s1_nb31_q   <= s1_nb31_d;
      res_q       <= res_d;
    end
  end

endmodule

// File: tb/tb_csel_subtractor_pipe.sv
// Scoreboard bench for csel_subtractor_pipe. The driver pushes the expected
// result at each accept. An independent monitor pops and compares each
// delivered result, and it also checks that outputs hold during a stall.
module tb_csel_subtractor_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] diff;
  logic        bout, zero, ovf;

  csel_subtractor_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        z;
    logic        ov;
    int          acyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  bit   rnd_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors with hand-computed results; the flags are {bout, zero, ovf}.
  localparam int NDIR = 9;
  logic [31:0] da [NDIR] = '{32'h5, 32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_ABCD,
                             32'hFFFF_FFFF, 32'h0000_0800, 32'h8000_0000, 32'h1};
  logic [31:0] db [NDIR] = '{32'h3, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'h1234_ABCD,
                             32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000};
  logic [31:0] dd [NDIR] = '{32'h2, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0,
                             32'h0, 32'h0000_07FF, 32'h1, 32'h8000_0001};
  logic [2:0]  df [NDIR] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010,
                             3'b010, 3'b000, 3'b001, 3'b101};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [2:0] f, input bit lat);
    exp_t e;
    e.d = d; e.bo = f[2]; e.z = f[1]; e.ov = f[0]; e.acyc = 0; e.lat = lat;
    return e;
  endfunction

  // Reference model: the 33-bit difference gives the borrow in bit 32.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [32:0] t;
    t    = {1'b0, x} - {1'b0, y};
    e.d  = t[31:0];
    e.bo = t[32];
    e.z  = (t[31:0] == 32'h0);
    e.ov = (x[31] != y[31]) && (t[31] != x[31]);
    e.acyc = 0; e.lat = 1'b0;
    return e;
  endfunction

  // Called at a negedge. Holds the pair until the DUT accepts it (sampled 1 ns before the edge).
  task automatic send(input logic [31:0] x, input logic [31:0] y, input exp_t e);
    bit done = 1'b0;
    in_valid = 1'b1; a = x; b = y;
    for (int t = 0; t < 500; t++) begin
      #4;
      if (in_ready) begin
        e.acyc = cyc;
        sb.push_back(e);
        acc_cnt++;
        done = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (done) break;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 500 cycles expected an accept (a=0x%08h b=0x%08h)", x, y);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: checks that a stalled output holds, and compares each delivered result with the scoreboard head.
  initial begin : monitor
    logic [31:0] hd;
    logic [2:0]  hf;
    bit          stalled;
    exp_t        e;
    stalled = 1'b0; hd = '0; hf = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("hold_valid", {31'b0, out_valid}, 32'h1);
        check("hold_diff", diff, hd);
        check("hold_flags", {29'b0, bout, zero, ovf}, {29'b0, hf});
      end
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got diff=0x%08h expected no output", diff);
        end else begin
          e = sb.pop_front();
          check("diff", diff, e.d);
          check("bout", {31'b0, bout}, {31'b0, e.bo});
          check("zero", {31'b0, zero}, {31'b0, e.z});
          check("ovf", {31'b0, ovf}, {31'b0, e.ov});
          if (e.lat) check("latency", cyc - e.acyc, 32'd2);
          $display("result diff=0x%08h bout=%0b zero=%0b ovf=%0b", diff, bout, zero, ovf);
        end
      end else if (out_valid) begin
        stalled = 1'b1;
        hd = diff;
        hf = {bout, zero, ovf};
      end
    end
  end

  // Random backpressure on out_ready during the random phase.
  initial begin : ready_toggler
    forever begin
      @(negedge clk);
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : main
    int          acc_base;
    logic [31:0] x, y;
    int          idle;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_diff", diff, 32'h0);
    check("rst_flags", {29'b0, bout, zero, ovf}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // Directed vectors, back to back, with no backpressure. Latency is checked.
    for (int i = 0; i < NDIR; i++) send(da[i], db[i], mk(dd[i], df[i], 1'b1));
    repeat (4) @(negedge clk);

    // Backpressure: hold out_ready low for 3 cycles while streaming 4 pairs.
    out_ready = 1'b0;
    acc_base  = acc_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) send(da[i], db[i], mk(dd[i], df[i], 1'b0));
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        check("bp_accepts", acc_cnt - acc_base, 32'd2);
        check("bp_in_ready", {31'b0, in_ready}, 32'h0);
        out_ready = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    check("bp_drained", sb.size(), 32'd0);

    // Reset while both stages hold data. The in-flight results must vanish.
    out_ready = 1'b0;
    send(32'd10, 32'd4, model(32'd10, 32'd4));
    send(32'd7, 32'd9, model(32'd7, 32'd9));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_diff", diff, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_no_stale", {31'b0, out_valid}, 32'h0);

    // Random pairs with random input gaps and random output backpressure.
    rnd_mode = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      idle = $urandom_range(0, 2);
      if (idle == 2) @(negedge clk);
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? x : $urandom;
      send(x, y, model(x, y));
    end
    rnd_mode = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    check("final_drain", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
